// File: rtl/reg_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : reg_ctrl_pkg                                               |
// | Description : Shared definitions for the round-robin register-load       |
// |               arbiter: FSM state encoding, default data width and an     |
// |               index-width helper.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package reg_ctrl_pkg;

  localparam int STATE_W        = 2;
  localparam int DATA_W_DEFAULT = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_load_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : reg_load_arbiter_if                                        |
// | Description : Requester/register side bundle of the register-load        |
// |               arbiter.                                                   |
// |   req       NREQ    per-requester load request (level)                   |
// |   req_data  NREQ*W  flattened load data, requester i at [i*W +: W]       |
// |   clr       1       global clear request pulse                           |
// |   gnt       NREQ    one-hot grant pulse                                  |
// |   reg_load  1       shared register load enable                          |
// |   reg_D     W       shared register D                                    |
// |   reg_reset 1       shared register synchronous reset                    |
// |   busy      1       arbiter not idle                                     |
// |   gnt_count NREQ*8  per-requester grant counters (ARB_STATS_EN only)     |
// | Modports    : master = requester side, slave = arbiter side              |
// | Config      : ARB_STATS_EN adds gnt_count                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface reg_load_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic              clr;
  logic [NREQ-1:0]   gnt;
  logic              reg_load;
  logic [W-1:0]      reg_D;
  logic              reg_reset;
  logic              busy;
`ifdef ARB_STATS_EN
  logic [NREQ*8-1:0] gnt_count;

  modport master (
    output req, req_data, clr,
    input  gnt, reg_load, reg_D, reg_reset, busy, gnt_count
  );

  modport slave (
    input  req, req_data, clr,
    output gnt, reg_load, reg_D, reg_reset, busy, gnt_count
  );
`else
  modport master (
    output req, req_data, clr,
    input  gnt, reg_load, reg_D, reg_reset, busy
  );

  modport slave (
    input  req, req_data, clr,
    output gnt, reg_load, reg_D, reg_reset, busy
  );
`endif

endinterface
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_priority_picker                                         |
// | Description : Combinational round-robin picker. Scans requesters         |
// |               starting just after the last winner, wrapping at NREQ-1.   |
// |   req     in   NREQ  request vector                                      |
// |   last    in   LW    index of the previous winner                         |
// |   onehot  out  NREQ  one-hot winner (zero when nobody requests)          |
// |   idx     out  LW    binary winner index                                 |
// |   valid   out  1     at least one request present                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_priority_picker #(
  parameter int NREQ = 4,
  parameter int LW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [LW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    // Offset k=NREQ comes back to last itself, so a lone requester that
    // just won can still win again.
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        idx       = LW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_load_arbiter                                           |
// | Description : Round-robin arbiter sharing one synchronous-reset/load     |
// |               register among NREQ requesters. Sequences clears (served   |
// |               first) and loads, and returns a one-cycle grant to the     |
// |               winner coincident with reg_load. All outputs registered.   |
// |   Clk      in  1   rising-edge clock                                     |
// |   reset_n  in  1   asynchronous active-low reset                         |
// |   bus      slave modport of reg_load_arbiter_if (req/req_data/clr in,    |
// |            gnt/reg_load/reg_D/reg_reset/busy[/gnt_count] out)           |
// | Parameters  : NREQ (2..8), W, HOLD_CYCLES (0..15)                         |
// | Config      : ARB_STATS_EN adds saturating 8-bit grant counters          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reg_load_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int W           = DATA_W_DEFAULT,
  parameter int HOLD_CYCLES = 1
) (
  input  logic               Clk,
  input  logic               reset_n,
  reg_load_arbiter_if.slave  bus
);

  localparam int         LW        = idx_width(NREQ);
  localparam logic [3:0] HOLD_LAST = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t          state;
  state_t          state_next;
  logic [LW-1:0]   last;
  logic            clr_pend;
  logic [3:0]      hold_cnt;

  logic [NREQ-1:0] win_onehot;
  logic [LW-1:0]   win_idx;
  logic            win_valid;

  logic            load_start;
  logic [NREQ-1:0] gnt_d;
  logic            reg_load_d;
  logic [W-1:0]    reg_D_d;
  logic            reg_reset_d;
  logic            busy_d;

  logic [NREQ-1:0] gnt_q;
  logic            reg_load_q;
  logic [W-1:0]    reg_D_q;
  logic            reg_reset_q;
  logic            busy_q;

  rr_priority_picker #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_picker (
    .req    (bus.req),
    .last   (last),
    .onehot (win_onehot),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  // State register plus the arbitration bookkeeping that moves with it.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= LW'(NREQ - 1);
      clr_pend <= 1'b0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      if (load_start) begin
        last <= win_idx;
      end
      // A clear arriving during CLEAR itself is kept for another pass;
      // otherwise CLEAR retires whatever was pending.
      clr_pend <= bus.clr | (clr_pend & (state != CLEAR));
      hold_cnt <= (state == HOLD) ? hold_cnt + 4'd1 : 4'd0;
    end
  end

  // Next-state logic: clears always beat loads out of IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clr_pend || bus.clr) begin
          state_next = CLEAR;
        end else if (win_valid) begin
          state_next = LOAD;
        end
      end
      CLEAR:   state_next = IDLE;
      LOAD:    state_next = (HOLD_CYCLES > 0) ? HOLD : IDLE;
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: values computed here become visible in the state being
  // entered, which is what makes gnt/reg_load coincide with LOAD.
  always_comb begin
    load_start  = (state == IDLE) && (state_next == LOAD);
    gnt_d       = load_start ? win_onehot : '0;
    reg_load_d  = load_start;
    // reg_D keeps the last loaded value between loads.
    reg_D_d     = load_start ? bus.req_data[win_idx*W +: W] : reg_D_q;
    reg_reset_d = (state_next == CLEAR);
    busy_d      = (state_next != IDLE);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q       <= '0;
      reg_load_q  <= 1'b0;
      reg_D_q     <= '0;
      reg_reset_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      reg_load_q  <= reg_load_d;
      reg_D_q     <= reg_D_d;
      reg_reset_q <= reg_reset_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.reg_load  = reg_load_q;
  assign bus.reg_D     = reg_D_q;
  assign bus.reg_reset = reg_reset_q;
  assign bus.busy      = busy_q;

`ifdef ARB_STATS_EN
  // Counters step on the same edge that raises gnt and clear on the edge
  // that leaves CLEAR.
  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    logic [7:0] cnt;

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= 8'd0;
      end else if (state == CLEAR) begin
        cnt <= 8'd0;
      end else if (gnt_d[i] && (cnt != 8'hFF)) begin
        cnt <= cnt + 8'd1;
      end
    end

    assign bus.gnt_count[i*8 +: 8] = cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reg_load_arbiter                                        |
// | Description : Directed self-checking bench for reg_load_arbiter with     |
// |               NREQ=4, W=4, HOLD_CYCLES=1. Inputs change 1 ns after the   |
// |               rising edge; outputs are sampled at the same point.        |
// | Config      : ARB_STATS_EN enables the grant-counter scenario            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_reg_load_arbiter;

  logic Clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  reg_load_arbiter_if #(.NREQ(4), .W(4)) bus ();

  reg_load_arbiter #(
    .NREQ        (4),
    .W           (4),
    .HOLD_CYCLES (1)
  ) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_gnt;
    logic [3:0] exp_d;
    reset_n      = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = 16'h4321;
    bus.clr      = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({bus.gnt, bus.reg_load, bus.reg_D, bus.reg_reset, bus.busy} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b load=%b D=%h rst=%b busy=%b, expected all 0",
               bus.gnt, bus.reg_load, bus.reg_D, bus.reg_reset, bus.busy);
    end
    reset_n = 1'b1;
    // Rotation 0,1,2,3,0 with LOAD, HOLD, IDLE for each grant.
    for (int g = 0; g < 5; g++) begin
      exp_gnt = 4'b0001 << (g % 4);
      exp_d   = 4'((g % 4) + 1);
      tick();
      tests_run++;
      if (bus.gnt !== exp_gnt || bus.reg_load !== 1'b1 || bus.reg_D !== exp_d) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: got gnt=%b load=%b D=%h, expected gnt=%b load=1 D=%h",
                 g, bus.gnt, bus.reg_load, bus.reg_D, exp_gnt, exp_d);
      end
      tick();
      tests_run++;
      if (bus.gnt !== 4'b0000 || bus.reg_load !== 1'b0 || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_hold_%0d: got gnt=%b load=%b busy=%b, expected 0000/0/1",
                 g, bus.gnt, bus.reg_load, bus.busy);
      end
      tick();
      tests_run++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_idle_%0d: got gnt=%b busy=%b, expected 0000/0", g, bus.gnt, bus.busy);
      end
    end
    bus.req = 4'b0000;
    tick();
  endtask

  // Last winner is requester 0 on entry.
  task automatic test_single_load();
    bus.req_data[11:8] = 4'hA;
    bus.req            = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tests_run++;
    if (bus.gnt !== 4'b0100 || bus.reg_load !== 1'b1 || bus.reg_D !== 4'hA || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_load: got gnt=%b load=%b D=%h busy=%b, expected 0100/1/a/1",
               bus.gnt, bus.reg_load, bus.reg_D, bus.busy);
    end
    tick();
    tests_run++;
    if (bus.busy !== 1'b1 || bus.reg_load !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_hold_busy: got busy=%b load=%b, expected 1/0", bus.busy, bus.reg_load);
    end
    tick();
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle_busy: got busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_clr_beats_load();
    bus.clr = 1'b1;
    bus.req = 4'b0001;
    tick();
    bus.clr = 1'b0;
    tests_run++;
    if (bus.reg_reset !== 1'b1 || bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_first: got rst=%b gnt=%b busy=%b, expected 1/0000/1",
               bus.reg_reset, bus.gnt, bus.busy);
    end
    tick();
    tests_run++;
    if (bus.reg_reset !== 1'b0 || bus.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL clr_gap: got rst=%b gnt=%b, expected 0/0000", bus.reg_reset, bus.gnt);
    end
    tick();
    bus.req = 4'b0000;
    tests_run++;
    if (bus.gnt !== 4'b0001 || bus.reg_load !== 1'b1 || bus.reg_D !== 4'h1) begin
      tests_failed++;
      $display("FAIL clr_then_load: got gnt=%b load=%b D=%h, expected 0001/1/1",
               bus.gnt, bus.reg_load, bus.reg_D);
    end
    repeat (2) tick();
  endtask

  task automatic test_clr_during_hold();
    bus.req = 4'b0010;
    tick();
    tests_run++;
    if (bus.gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL hold_pre_grant: got gnt=%b, expected 0010", bus.gnt);
    end
    bus.req = 4'b1000;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    tests_run++;
    if (bus.reg_reset !== 1'b0 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_pend_idle: got rst=%b gnt=%b busy=%b, expected 0/0000/0",
               bus.reg_reset, bus.gnt, bus.busy);
    end
    tick();
    tests_run++;
    if (bus.reg_reset !== 1'b1 || bus.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hold_pend_clear: got rst=%b gnt=%b, expected 1/0000", bus.reg_reset, bus.gnt);
    end
    tick();
    tests_run++;
    if (bus.reg_reset !== 1'b0 || bus.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hold_single_clear: got rst=%b gnt=%b, expected 0/0000", bus.reg_reset, bus.gnt);
    end
    tick();
    bus.req = 4'b0000;
    tests_run++;
    if (bus.gnt !== 4'b1000 || bus.reg_D !== 4'h4) begin
      tests_failed++;
      $display("FAIL hold_after_clear_load: got gnt=%b D=%h, expected 1000/4", bus.gnt, bus.reg_D);
    end
    repeat (2) tick();
  endtask

  // Request dropped while another requester is being served gets no grant.
  task automatic test_withdraw();
    bus.req = 4'b0011;
    tick();
    bus.req = 4'b0000;
    tests_run++;
    if (bus.gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL withdraw_first: got gnt=%b, expected 0001", bus.gnt);
    end
    repeat (3) tick();
    tests_run++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL withdraw_no_grant: got gnt=%b busy=%b, expected 0000/0", bus.gnt, bus.busy);
    end
  endtask

  // Last winner is 0 here; 0110 normally goes to 1, and after an aborted
  // load the reset pointer must again pick the lowest index (1), not 2.
  task automatic test_reset_during_load();
    bus.req = 4'b0110;
    tick();
    tests_run++;
    if (bus.gnt !== 4'b0010 || bus.reg_load !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre_grant: got gnt=%b load=%b, expected 0010/1", bus.gnt, bus.reg_load);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.reg_load !== 1'b0 || bus.gnt !== 4'b0000 || bus.reg_D !== 4'h0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_async: got load=%b gnt=%b D=%h busy=%b, expected 0/0000/0/0",
               bus.reg_load, bus.gnt, bus.reg_D, bus.busy);
    end
    tick();
    reset_n = 1'b1;
    tick();
    bus.req = 4'b0000;
    tests_run++;
    if (bus.gnt !== 4'b0010 || bus.reg_D !== 4'h2) begin
      tests_failed++;
      $display("FAIL abort_lowest: got gnt=%b D=%h, expected 0010/2", bus.gnt, bus.reg_D);
    end
    repeat (2) tick();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    bus.req = 4'b0010;
    repeat (905) tick();
    bus.req = 4'b0000;
    repeat (3) tick();
    tests_run++;
    if (bus.gnt_count[15:8] !== 8'd255) begin
      tests_failed++;
      $display("FAIL stats_saturate: got %0d, expected 255", bus.gnt_count[15:8]);
    end
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (bus.gnt_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats_clear: got %h, expected 00000000", bus.gnt_count);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_data = 16'h4321;
    bus.clr      = 1'b0;
    test_reset();
    test_single_load();
    test_clr_beats_load();
    test_clr_during_hold();
    test_withdraw();
    test_reset_during_load();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
